// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: stage-control word,
// control modes and performance-counter indices.
package pipeline_ctrl_pkg;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic bubble_id_ex;
    logic flush_id_ex;
  } stage_ctrl_t;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_HOLD,
    MODE_REDIRECT,
    MODE_BUBBLE,
    MODE_RUN
  } ctrl_mode_e;

  typedef enum logic [1:0] {
    CNT_BUBBLE,
    CNT_IMEM_STALL,
    CNT_DMEM_STALL,
    CNT_FLUSH
  } cnt_idx_e;

  localparam int NUM_CNT = 4;

  // Reset pushes NOPs into every stage register; hold freezes the whole pipe.
  function automatic stage_ctrl_t stage_ctrl_for(input ctrl_mode_e mode);
    stage_ctrl_t c;
    c = '0;
    case (mode)
      MODE_RESET: c = '1;
      MODE_HOLD:  c = '0;
      MODE_REDIRECT: begin
        c = '1;
        c.bubble_id_ex = 1'b0;
      end
      MODE_BUBBLE: begin
        c.load_id_ex   = 1'b1;
        c.load_ex_mem  = 1'b1;
        c.load_mem_wb  = 1'b1;
        c.bubble_id_ex = 1'b1;
      end
      default: begin
        c.load_pc     = 1'b1;
        c.load_if_id  = 1'b1;
        c.load_id_ex  = 1'b1;
        c.load_ex_mem = 1'b1;
        c.load_mem_wb = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the pipeline controller (slave) and its
// surrounding pipeline (master). Names are from the controller's viewpoint.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic i_load_use_stall;
  logic i_redirect;
  logic i_imem_read;
  logic i_imem_resp;
  logic i_dmem_read;
  logic i_dmem_write;
  logic i_dmem_resp;

  logic o_imem_req_en;
  logic o_dmem_req_en;
  logic o_load_pc;
  logic o_load_if_id;
  logic o_load_id_ex;
  logic o_load_ex_mem;
  logic o_load_mem_wb;
  logic o_flush_if_id;
  logic o_bubble_id_ex;
  logic o_flush_id_ex;
  logic o_frozen;

  modport slave (
    input  i_load_use_stall, i_redirect, i_imem_read, i_imem_resp,
           i_dmem_read, i_dmem_write, i_dmem_resp,
    output o_imem_req_en, o_dmem_req_en, o_load_pc, o_load_if_id,
           o_load_id_ex, o_load_ex_mem, o_load_mem_wb, o_flush_if_id,
           o_bubble_id_ex, o_flush_id_ex, o_frozen
  );

  modport master (
    output i_load_use_stall, i_redirect, i_imem_read, i_imem_resp,
           i_dmem_read, i_dmem_write, i_dmem_resp,
    input  o_imem_req_en, o_dmem_req_en, o_load_pc, o_load_if_id,
           o_load_id_ex, o_load_ex_mem, o_load_mem_wb, o_flush_if_id,
           o_bubble_id_ex, o_flush_id_ex, o_frozen
  );

endinterface

// File: rtl/pipeline_ctrl_mem_port_tracker.sv
// One memory port's "already completed" latch: remembers a response that
// arrived while the pipe was frozen so the access is not re-issued.
module mem_port_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_resp,
  input  logic i_adv,
  output logic o_ok,
  output logic o_req_en
);

  logic r_done;

  // A response seen in an advancing cycle is consumed immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else if (i_adv) begin
      r_done <= 1'b0;
    end else begin
      r_done <= r_done | i_resp;
    end
  end

  assign o_ok     = !i_req | i_resp | r_done;
  assign o_req_en = !rst & !r_done;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush responder for the 5-stage rv32i pipeline.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_bubble,
  output logic [CNT_W-1:0] o_cnt_imem_stall,
  output logic [CNT_W-1:0] o_cnt_dmem_stall,
  output logic [CNT_W-1:0] o_cnt_flush
`endif
);

  logic        w_i_ok;
  logic        w_d_ok;
  logic        w_adv;
  logic        w_frozen;
  logic        w_imem_req_en;
  logic        w_dmem_req_en;
  ctrl_mode_e  w_mode;
  stage_ctrl_t w_ctrl;

  mem_port_tracker u_imem (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.i_imem_read),
    .i_resp   (bus.i_imem_resp),
    .i_adv    (w_adv),
    .o_ok     (w_i_ok),
    .o_req_en (w_imem_req_en)
  );

  mem_port_tracker u_dmem (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.i_dmem_read | bus.i_dmem_write),
    .i_resp   (bus.i_dmem_resp),
    .i_adv    (w_adv),
    .o_ok     (w_d_ok),
    .o_req_en (w_dmem_req_en)
  );

  assign w_adv    = w_i_ok & w_d_ok;
  assign w_frozen = !rst & !w_adv;

  // Priority: reset, memory hold, redirect (beats load-use), load-use bubble.
  always_comb begin
    w_mode = MODE_RUN;
    if (rst) begin
      w_mode = MODE_RESET;
    end else if (!w_adv) begin
      w_mode = MODE_HOLD;
    end else if (bus.i_redirect) begin
      w_mode = MODE_REDIRECT;
    end else if (bus.i_load_use_stall) begin
      w_mode = MODE_BUBBLE;
    end
  end

  assign w_ctrl = stage_ctrl_for(w_mode);

  assign bus.o_imem_req_en  = w_imem_req_en;
  assign bus.o_dmem_req_en  = w_dmem_req_en;
  assign bus.o_load_pc      = w_ctrl.load_pc;
  assign bus.o_load_if_id   = w_ctrl.load_if_id;
  assign bus.o_load_id_ex   = w_ctrl.load_id_ex;
  assign bus.o_load_ex_mem  = w_ctrl.load_ex_mem;
  assign bus.o_load_mem_wb  = w_ctrl.load_mem_wb;
  assign bus.o_flush_if_id  = w_ctrl.flush_if_id;
  assign bus.o_bubble_id_ex = w_ctrl.bubble_id_ex;
  assign bus.o_flush_id_ex  = w_ctrl.flush_id_ex;
  assign bus.o_frozen       = w_frozen;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] w_inc;

  always_comb begin
    w_inc                 = '0;
    w_inc[CNT_BUBBLE]     = (w_mode == MODE_BUBBLE);
    w_inc[CNT_IMEM_STALL] = w_frozen & !w_i_ok;
    w_inc[CNT_DMEM_STALL] = w_frozen & !w_d_ok;
    w_inc[CNT_FLUSH]      = (w_mode == MODE_REDIRECT);
  end

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rst) begin
        r_cnt[k] <= '0;
      end else if (w_inc[k]) begin
        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  assign o_cnt_bubble     = r_cnt[CNT_BUBBLE];
  assign o_cnt_imem_stall = r_cnt[CNT_IMEM_STALL];
  assign o_cnt_dmem_stall = r_cnt[CNT_DMEM_STALL];
  assign o_cnt_flush      = r_cnt[CNT_FLUSH];
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush responder for the 5-stage rv32i pipeline. Consumes the load-use stall request from the hazard unit, the EX-stage redirect and the I/D memory handshakes.
- Drives per-stage pipeline-register load enables, bubble and flush controls, and per-port request masks.
- Holds "already-completed" state for each memory port so that a finished access is not re-issued while the other port is still waiting.

Parameters:
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- load_use_stall  in  1  hazard unit: ID instruction depends on a load in EX
- redirect  in  1  EX: taken branch/jump, PC must load target
- imem_read  in  1  IF fetch request (raw, before masking)
- imem_resp  in  1  I-side response, 1-cycle pulse
- dmem_read  in  1  MEM load request (raw)
- dmem_write  in  1  MEM store request (raw)
- dmem_resp  in  1  D-side response, 1-cycle pulse
- imem_req_en  out  1  gate ANDed onto imem_read toward memory
- dmem_req_en  out  1  gate ANDed onto dmem_read/dmem_write toward memory
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- flush_if_id  out  1  load a NOP into IF/ID
- bubble_id_ex  out  1  load a NOP control word into ID/EX
- flush_id_ex  out  1  same effect as bubble_id_ex; separate so the source can be traced
- frozen  out  1  high while any stage is held by memory wait

Behaviour:
- State: imem_done, dmem_done (1 bit each). All outputs are combinational from state and inputs.
- Per-port satisfaction:
  - i_ok = !imem_read | imem_resp | imem_done
  - d_ok = !(dmem_read|dmem_write) | dmem_resp | dmem_done
- adv = i_ok & d_ok; frozen = !adv.
- Done latches:
  - imem_done <= adv ? 0 : (imem_done | imem_resp). dmem_done follows the same rule.
  - A response arriving in the adv cycle is consumed that cycle; the latch stays 0.
- Request masks: imem_req_en = !imem_done; dmem_req_en = !dmem_done. A completed port issues no duplicate request while frozen.
- adv=0: every load_* = 0; flush_if_id = bubble_id_ex = flush_id_ex = 0. The whole pipeline holds, including WB.
- adv=1, redirect=1:
  - load_pc = 1 (target), flush_if_id = 1, flush_id_ex = 1, all other loads = 1.
  - load_use_stall is ignored (redirect wins).
- adv=1, load_use_stall=1, redirect=0:
  - load_pc = 0, load_if_id = 0, bubble_id_ex = 1.
  - load_id_ex, load_ex_mem, load_mem_wb = 1.
  - Gives exactly one bubble per assertion cycle.
- adv=1, neither: all loads = 1, no flush/bubble.
- Load-use while frozen: no bubble is inserted until adv. Bubble count equals the number of adv cycles with load_use_stall high.
- Both responses in the same cycle: adv=1 and both latches stay 0.
- One response early: its latch sets and the port is masked until the other responds.
- Reset: imem_done = dmem_done = 0.
  - While rst is high: all load_* = 1, flush_if_id = flush_id_ex = bubble_id_ex = 1 (pipeline cleared to NOPs), imem_req_en = dmem_req_en = 0, frozen = 0.
  - Reset during an outstanding miss discards the latched completion.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds outputs cnt_bubble, cnt_imem_stall, cnt_dmem_stall, cnt_flush (CNT_W each, out). Increments per cycle:
  - cnt_bubble: on adv & load_use_stall & !redirect.
  - cnt_imem_stall: on frozen & !i_ok.
  - cnt_dmem_stall: on frozen & !d_ok.
  - cnt_flush: on adv & redirect.
  - All counters wrap modulo 2^CNT_W and are zeroed by rst.
- Undefined: no counter ports or logic; behaviour otherwise identical.

Decomposition:
- rv32i_types: add a stage-control typedef struct (load, flush bits per stage) and an enum for counter index.
- One sub-module, mem_port_tracker: holds one done latch and produces ok and req_en. Instantiated twice, I and D.

Test Plan:
- No requests, no hazards for 5 cycles -> all load_*=1, frozen=0, no flush.
- load_use_stall=1 for 1 cycle with no memory wait -> load_pc=0, load_if_id=0, bubble_id_ex=1 for exactly that cycle; full flow the next cycle.
- imem_read with resp 3 cycles later, dmem_read with resp 6 cycles later:
  - frozen 6 cycles.
  - imem_req_en drops after cycle 3.
  - adv at cycle 6.
  - imem_done clears on adv.
- redirect=1 and load_use_stall=1 in the same cycle -> load_pc=1, flush_if_id=1, flush_id_ex=1, bubble_id_ex=0.
- dmem_write outstanding with rst asserted mid-wait -> dmem_done=0 and dmem_req_en=0 during rst; after rst deasserts, dmem_req_en=1 and frozen=0.
- PIPE_PERF_CNT_EN: 2 bubbles, 4 imem-stall cycles, 1 redirect -> counters read 2/4/0/1; rst clears all to 0.
